alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single combinational 16-bit ALU between two requesters (r0 = execute unit, r1 = address/aux unit).
//  Round-robin grants one request at a time, drives the ALU from registered operands, then captures y, the high
//  product word (outToA) and the flags {C,N,Z,V}. Returns them on a valid/ready response port tagged with the requester id.
// PARAMETERS
//  WIDTH       16  operand/result width; must match the ALU instance
//  FIXED_PRIO  0   0 = round-robin between r0/r1; 1 = r0 always wins
// PORTS
//  clk          in   1      single clock; all state changes on rising edge
//  rst          in   1      synchronous, active-high reset
//  r0_valid     in   1      r0 request valid; r0 holds r0_a/b/func/ci stable until r0_ready
//  r0_ready     out  1      r0 request accepted this cycle
//  r0_a, r0_b   in   WIDTH  r0 operands
//  r0_func      in   4      r0 ALU function code
//  r0_ci        in   1      r0 carry-in
//  r1_*         -    -      same set as r0_* for requester 1
//  alu_a        out  WIDTH  to ALU a (registered)
//  alu_b        out  WIDTH  to ALU b (registered)
//  alu_func     out  4      to ALU func (registered)
//  alu_ci       out  1      to ALU ci (registered)
//  alu_y        in   WIDTH  from ALU y
//  alu_to_a     in   WIDTH  from ALU outToA (high word for MUL)
//  alu_flags    in   4      from ALU {co,negative,zero,overflow}
//  rsp_valid    out  1      response valid
//  rsp_ready    in   1      consumer accepts response
//  rsp_id       out  1      requester served (0 = r0, 1 = r1)
//  rsp_y        out  WIDTH  captured result
//  rsp_hi       out  WIDTH  captured outToA; meaningful only for func 4'b0100 (MUL)
//  rsp_flags    out  4      captured {C,N,Z,V}
//  flags        out  4      architectural flag register; last captured flags
// BEHAVIOUR
//  Reset: state IDLE. rsp_valid=0, r0_ready=r1_ready=0, rsp_id=0, rsp_y=rsp_hi=0, rsp_flags=flags=0,
//   alu_a=alu_b=0, alu_func=0, alu_ci=0, round-robin pointer favours r0.
//  FSM IDLE -> EXEC -> RESP -> IDLE:
//   IDLE: rN_ready = grant_N (combinational, IDLE only). At most one ready is high.
//    On handshake (cycle 0), latch the granted operands into alu_* and the id, then go to EXEC.
//    With no valid request, stay in IDLE.
//   EXEC (cycle 1): the ALU settles on the registered inputs. At the cycle end, capture alu_y, alu_to_a and
//    alu_flags into rsp_y/rsp_hi/rsp_flags and into flags. Go to RESP.
//   RESP (cycle 2+): rsp_valid=1. rsp_* are held stable until rsp_valid&&rsp_ready. Then go to IDLE.
//    No request is accepted in RESP, so peak throughput is 1 op per 3 cycles.
//  Latency: handshake in cycle 0 -> rsp_valid first high in cycle 2.
//  Arbitration, round-robin: if both valid, grant the requester not served last.
//   After a grant, the pointer flips to the other requester. The pointer is updated only on a handshake.
//   FIXED_PRIO=1: r0 wins whenever r0_valid.
//  Grant is evaluated only in IDLE. A request whose valid drops before its ready is simply not served.
//  alu_* hold their last value outside EXEC; the ALU output is ignored outside EXEC.
//  flags changes only at EXEC capture. It is never modified by requests still waiting.
//  rst while in EXEC/RESP aborts the op: no response is issued, flags return to 0, state goes to IDLE next cycle.
//  Width rules: all data is WIDTH bits with no extension. rsp_hi is passed through, never computed here.
// STRUCTURE
//  Shared header alu_defs.vh:
//   - func encodings ADD 0000, ADC 0001, SUB 0010, SBC 0011, MUL 0100, MLL 0101, RAS 0111, LSH 1000, RSH 1001,
//     LRT 1010, RRT 1011, AND 1100, OR 1101, XOR 1110, NOT 1111
//   - flag bit indices C=3, N=2, Z=1, V=0
//   - FSM state encodings IDLE/EXEC/RESP
//  Sub-module rr_arbiter2: 2-way grant plus pointer, with a FIXED_PRIO parameter.
//  The ALU itself is instantiated beside this block, not inside it.
// TESTING (bench instantiates alu_arbiter + ALU; rsp_ready=1 unless stated)
//  1. r0 ADD a=15 b=25 -> r0_ready in cycle 0, rsp_valid in cycle 2, rsp_y=40, rsp_flags=0000, rsp_id=0, flags=0000.
//  2. r1 MUL a=256 b=256 -> rsp_y=0, rsp_hi=1, rsp_flags=0000, rsp_id=1.
//  3. Both valid every cycle (r0 ADD 16'h4000+16'h4000, r1 SUB a=-10 b=70, ci=1) -> served r0, r1, r0, r1.
//     r0 responses: y=16'h8000, flags=0101. r1 responses: y=-80, flags=0100.
//     With FIXED_PRIO=1, only r0 is served.
//  4. Backpressure: rsp_ready=0 for 3 cycles after rsp_valid -> rsp_* stable, r0_ready=r1_ready=0 throughout.
//     Next grant comes the cycle after the rsp handshake.
//  5. rst pulsed during EXEC of r0 ADD a=-1 b=1 -> no rsp_valid, flags=0000, next request served normally.
//  6. Flags chaining: ADD 16'h8000+16'h8000 -> flags=1011. A following r1 NOT a=16'h3333 -> rsp_y=16'hCCCC, flags=0100.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: function codes, flag
// bit positions and controller state encodings.
package alu_arbiter_pkg;

  typedef enum logic [3:0] {
    FN_ADD = 4'b0000,
    FN_ADC = 4'b0001,
    FN_SUB = 4'b0010,
    FN_SBC = 4'b0011,
    FN_MUL = 4'b0100,
    FN_MLL = 4'b0101,
    FN_RAS = 4'b0111,
    FN_LSH = 4'b1000,
    FN_RSH = 4'b1001,
    FN_LRT = 4'b1010,
    FN_RRT = 4'b1011,
    FN_AND = 4'b1100,
    FN_OR  = 4'b1101,
    FN_XOR = 4'b1110,
    FN_NOT = 4'b1111
  } alu_func_e;

  // Bit positions inside the {C,N,Z,V} flag nibble.
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_arbiter_arb.sv
// Two-way grant logic with a one-bit round-robin pointer; the pointer moves
// only when a grant is actually issued.
module rr_arbiter2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic favour_r1_reg;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (FIXED_PRIO) begin
        grant = req[0] ? 2'b01 : {req[1], 1'b0};
      end else if (req == 2'b11) begin
        grant = favour_r1_reg ? 2'b10 : 2'b01;
      end else begin
        grant = req;
      end
    end
  end

  // After serving r0 favour r1, and vice versa.
  always_ff @(posedge clk) begin
    if (srst) begin
      favour_r1_reg <= 1'b0;
    end else if (|grant) begin
      favour_r1_reg <= grant[0];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters: grant in IDLE,
// let the ALU settle on registered operands in EXEC, hold the result in RESP.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [3:0]       r0_func,
  input  logic             r0_ci,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [3:0]       r1_func,
  input  logic             r1_ci,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_func,
  output logic             alu_ci,
  input  logic [WIDTH-1:0] alu_y,
  input  logic [WIDTH-1:0] alu_to_a,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [3:0]       rsp_flags,
  output logic [3:0]       flags
);

  logic [1:0]       state_reg, state_next;
  logic [1:0]       grant;
  logic [WIDTH-1:0] alu_a_reg, alu_b_reg, rsp_y_reg, rsp_hi_reg;
  logic [3:0]       alu_func_reg, rsp_flags_reg, flags_reg;
  logic             alu_ci_reg, id_reg;

  rr_arbiter2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk    (clk),
    .srst   (rst),
    .enable (state_reg == ST_IDLE),
    .req    ({r1_valid, r0_valid}),
    .grant  (grant)
  );

  // A grant is only ever given to a valid requester, so a grant is a handshake.
  assign r0_ready  = grant[0];
  assign r1_ready  = grant[1];
  assign rsp_valid = (state_reg == ST_RESP);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (|grant) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_func_reg  <= '0;
      alu_ci_reg    <= 1'b0;
      id_reg        <= 1'b0;
      rsp_y_reg     <= '0;
      rsp_hi_reg    <= '0;
      rsp_flags_reg <= '0;
      flags_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (|grant) begin
        alu_a_reg    <= grant[1] ? r1_a    : r0_a;
        alu_b_reg    <= grant[1] ? r1_b    : r0_b;
        alu_func_reg <= grant[1] ? r1_func : r0_func;
        alu_ci_reg   <= grant[1] ? r1_ci   : r0_ci;
        id_reg       <= grant[1];
      end
      // The ALU output is only trusted at the end of EXEC.
      if (state_reg == ST_EXEC) begin
        rsp_y_reg     <= alu_y;
        rsp_hi_reg    <= alu_to_a;
        rsp_flags_reg <= alu_flags;
        flags_reg     <= alu_flags;
      end
    end
  end

  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_func  = alu_func_reg;
  assign alu_ci    = alu_ci_reg;
  assign rsp_id    = id_reg;
  assign rsp_y     = rsp_y_reg;
  assign rsp_hi    = rsp_hi_reg;
  assign rsp_flags = rsp_flags_reg;
  assign flags     = flags_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: a behavioural ALU sits beside each arbiter instance and
// a small arbitration model predicts grant order, results and timing.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rsp_ready;
  logic        r0_valid, r1_valid, r0_ci, r1_ci;
  logic [15:0] r0_a, r0_b, r1_a, r1_b;
  logic [3:0]  r0_func, r1_func;

  logic        r0_ready, r1_ready, alu_ci, rsp_valid, rsp_id;
  logic [15:0] alu_a, alu_b, alu_y, alu_to_a, rsp_y, rsp_hi;
  logic [3:0]  alu_func, alu_flags, rsp_flags, flags;

  logic        fp_r0_ready, fp_r1_ready, fp_alu_ci, fp_rsp_valid, fp_rsp_id;
  logic [15:0] fp_alu_a, fp_alu_b, fp_alu_y, fp_alu_to_a, fp_rsp_y, fp_rsp_hi;
  logic [3:0]  fp_alu_func, fp_alu_flags, fp_rsp_flags, fp_flags;

  typedef struct packed {
    logic [15:0] y;
    logic [15:0] hi;
    logic [3:0]  fl;
  } alu_out_t;

  // Reference ALU; flags are {C,N,Z,V}, C is the borrow for subtraction.
  function automatic alu_out_t alu_model(logic [15:0] a, logic [15:0] b, logic [3:0] f, logic ci);
    alu_out_t o;
    logic [16:0] s;
    logic [31:0] p;
    logic c, v, n, z;
    int sh;
    o = '0; c = 1'b0; v = 1'b0; sh = int'(b[3:0]);
    p = 32'(a) * 32'(b);
    case (f)
      4'b0000, 4'b0001: begin
        s = {1'b0, a} + {1'b0, b} + ((f == 4'b0001) ? 17'(ci) : 17'd0);
        o.y = s[15:0]; c = s[16];
        v = (a[15] == b[15]) && (o.y[15] != a[15]);
      end
      4'b0010, 4'b0011: begin
        s = {1'b0, a} - {1'b0, b} - ((f == 4'b0011) ? 17'(ci) : 17'd0);
        o.y = s[15:0]; c = s[16];
        v = (a[15] != b[15]) && (o.y[15] != a[15]);
      end
      4'b0100, 4'b0101: begin o.y = p[15:0]; o.hi = p[31:16]; end
      4'b0111: o.y = 16'($signed(a) >>> sh);
      4'b1000: o.y = a << sh;
      4'b1001: o.y = a >> sh;
      4'b1010: o.y = (a << sh) | ((sh == 0) ? 16'h0 : (a >> (16 - sh)));
      4'b1011: o.y = (a >> sh) | ((sh == 0) ? 16'h0 : (a << (16 - sh)));
      4'b1100: o.y = a & b;
      4'b1101: o.y = a | b;
      4'b1110: o.y = a ^ b;
      4'b1111: o.y = ~a;
      default: o.y = 16'h0;
    endcase
    if (f == 4'b0100) begin n = p[31]; z = (p == 32'h0); end
    else begin n = o.y[15]; z = (o.y == 16'h0); end
    o.fl = {c, n, z, v};
    return o;
  endfunction

  alu_out_t alu_res, fp_alu_res;
  always_comb alu_res    = alu_model(alu_a, alu_b, alu_func, alu_ci);
  always_comb fp_alu_res = alu_model(fp_alu_a, fp_alu_b, fp_alu_func, fp_alu_ci);
  assign alu_y        = alu_res.y;
  assign alu_to_a     = alu_res.hi;
  assign alu_flags    = alu_res.fl;
  assign fp_alu_y     = fp_alu_res.y;
  assign fp_alu_to_a  = fp_alu_res.hi;
  assign fp_alu_flags = fp_alu_res.fl;

  alu_arbiter #(.WIDTH(16), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_func(r0_func), .r0_ci(r0_ci),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_func(r1_func), .r1_ci(r1_ci),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_ci(alu_ci),
    .alu_y(alu_y), .alu_to_a(alu_to_a), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .rsp_hi(rsp_hi), .rsp_flags(rsp_flags), .flags(flags)
  );

  alu_arbiter #(.WIDTH(16), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(fp_r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_func(r0_func), .r0_ci(r0_ci),
    .r1_valid(r1_valid), .r1_ready(fp_r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_func(r1_func), .r1_ci(r1_ci),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_func(fp_alu_func), .alu_ci(fp_alu_ci),
    .alu_y(fp_alu_y), .alu_to_a(fp_alu_to_a), .alu_flags(fp_alu_flags),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id), .rsp_y(fp_rsp_y),
    .rsp_hi(fp_rsp_hi), .rsp_flags(fp_rsp_flags), .flags(fp_flags)
  );

  int checks = 0;
  int errors = 0;
  bit model_favour = 1'b0;  // 1 = round-robin pointer favours r1

  task automatic drive(input bit id, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] f, input logic c);
    if (id) begin r1_a = a; r1_b = b; r1_func = f; r1_ci = c; r1_valid = 1'b1; end
    else    begin r0_a = a; r0_b = b; r0_func = f; r0_ci = c; r0_valid = 1'b1; end
  endtask

  task automatic release_req(input bit id);
    if (id) r1_valid = 1'b0; else r0_valid = 1'b0;
  endtask

  // Present one request and hold it until accepted (bounded); returns cycles waited.
  task automatic send(input bit id, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] f, input logic c, output int wc, output bit ok);
    @(posedge clk); #1;
    drive(id, a, b, f, c);
    wc = 0;
    @(negedge clk);
    while (!(id ? r1_ready : r0_ready) && wc < 20) begin wc++; @(negedge clk); end
    ok = id ? r1_ready : r0_ready;
    @(posedge clk); #1;
    release_req(id);
  endtask

  // Wait for a response (bounded), sample it, and let it be consumed.
  task automatic recv(output bit ok, output int lat, output logic id, output logic [15:0] y,
                      output logic [15:0] hi, output logic [3:0] fl, output logic [3:0] fg);
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin lat++; @(negedge clk); end
    ok = rsp_valid; id = rsp_id; y = rsp_y; hi = rsp_hi; fl = rsp_flags; fg = flags;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_favour = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || r0_ready !== 1'b0 || r1_ready !== 1'b0 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got valid=%b r0_ready=%b r1_ready=%b id=%b, expected all 0",
               rsp_valid, r0_ready, r1_ready, rsp_id);
    end
    checks++;
    if (rsp_y !== 16'h0 || rsp_hi !== 16'h0 || rsp_flags !== 4'h0 || flags !== 4'h0) begin
      errors++;
      $display("FAIL reset_rsp: got y=%h hi=%h rflags=%b flags=%b, expected all 0", rsp_y, rsp_hi, rsp_flags, flags);
    end
    checks++;
    if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_func !== 4'h0 || alu_ci !== 1'b0) begin
      errors++;
      $display("FAIL reset_alu: got a=%h b=%h func=%h ci=%b, expected all 0", alu_a, alu_b, alu_func, alu_ci);
    end
  endtask

  task automatic test_basic_add();
    int wc, lat; bit ok, ok2; logic id; logic [15:0] y, hi; logic [3:0] fl, fg;
    send(1'b0, 16'd15, 16'd25, 4'b0000, 1'b0, wc, ok);
    model_favour = 1'b1;
    checks++;
    if (!ok || wc != 0) begin errors++; $display("FAIL add_ready: got ok=%b wait=%0d, expected ready in cycle 0", ok, wc); end
    recv(ok2, lat, id, y, hi, fl, fg);
    checks++;
    if (!ok2 || lat != 2) begin errors++; $display("FAIL add_latency: got ok=%b lat=%0d, expected 2", ok2, lat); end
    checks++;
    if (y !== 16'd40 || fl !== 4'b0000 || id !== 1'b0 || fg !== 4'b0000) begin
      errors++;
      $display("FAIL add_result: got y=%0d fl=%b id=%b flags=%b, expected 40 0000 0 0000", y, fl, id, fg);
    end
  endtask

  task automatic test_mul();
    int wc, lat; bit ok, ok2; logic id; logic [15:0] y, hi; logic [3:0] fl, fg;
    send(1'b1, 16'd256, 16'd256, 4'b0100, 1'b0, wc, ok);
    model_favour = 1'b0;
    recv(ok2, lat, id, y, hi, fl, fg);
    checks++;
    if (!ok || !ok2 || lat != 2 || y !== 16'h0 || hi !== 16'h1 || fl !== 4'b0000 || id !== 1'b1) begin
      errors++;
      $display("FAIL mul_result: got ok=%b/%b lat=%0d y=%h hi=%h fl=%b id=%b, expected lat 2 y=0000 hi=0001 fl=0000 id=1",
               ok, ok2, lat, y, hi, fl, id);
    end
  endtask

  task automatic test_flags_chain();
    int wc, lat; bit ok, ok2; logic id; logic [15:0] y, hi; logic [3:0] fl, fg;
    send(1'b0, 16'h8000, 16'h8000, 4'b0000, 1'b0, wc, ok);
    model_favour = 1'b1;
    recv(ok2, lat, id, y, hi, fl, fg);
    checks++;
    if (!ok || !ok2 || y !== 16'h0 || fl !== 4'b1011 || fg !== 4'b1011) begin
      errors++;
      $display("FAIL chain_add: got y=%h fl=%b flags=%b, expected 0000 1011 1011", y, fl, fg);
    end
    send(1'b1, 16'h3333, 16'h0000, 4'b1111, 1'b0, wc, ok);
    model_favour = 1'b0;
    recv(ok2, lat, id, y, hi, fl, fg);
    checks++;
    if (!ok || !ok2 || y !== 16'hCCCC || fl !== 4'b0100 || fg !== 4'b0100 || id !== 1'b1) begin
      errors++;
      $display("FAIL chain_not: got y=%h fl=%b flags=%b id=%b, expected cccc 0100 0100 1", y, fl, fg, id);
    end
  endtask

  task automatic test_reset_abort();
    int wc, lat; bit ok, ok2, bad; logic id; logic [15:0] y, hi; logic [3:0] fl, fg;
    send(1'b0, 16'hFFFF, 16'h0001, 4'b0000, 1'b0, wc, ok);
    // now in EXEC: pulse reset across its closing edge
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_favour = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || flags !== 4'b0000) bad = 1'b1;
    end
    checks++;
    if (!ok || bad) begin errors++; $display("FAIL abort_quiet: got ok=%b bad=%b flags=%b, expected no response and flags 0000", ok, bad, flags); end
    send(1'b0, 16'd1, 16'd2, 4'b0000, 1'b0, wc, ok);
    model_favour = 1'b1;
    recv(ok2, lat, id, y, hi, fl, fg);
    checks++;
    if (!ok || !ok2 || lat != 2 || y !== 16'd3 || fl !== 4'b0000 || id !== 1'b0) begin
      errors++;
      $display("FAIL abort_next: got ok=%b/%b lat=%0d y=%h fl=%b id=%b, expected lat 2 y=0003 fl=0000 id=0", ok, ok2, lat, y, fl, id);
    end
  endtask

  task automatic test_round_robin();
    bit exp_q[$];
    bit exp_id, g;
    int rsps, fp_rsps, cyc;
    do_reset();
    drive(1'b0, 16'h4000, 16'h4000, 4'b0000, 1'b0);
    drive(1'b1, 16'hFFF6, 16'd70, 4'b0010, 1'b1);
    rsps = 0; fp_rsps = 0; cyc = 0;
    while (rsps < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (r0_ready || r1_ready) begin
        g = r1_ready;
        checks++;
        if ((r0_ready && r1_ready) || g !== model_favour) begin
          errors++;
          $display("FAIL rr_grant: got r0_ready=%b r1_ready=%b, expected requester %0d", r0_ready, r1_ready, model_favour);
        end
        exp_q.push_back(model_favour);
        model_favour = !model_favour;
      end
      if (rsp_valid) begin
        exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
        checks++;
        if (rsp_id !== exp_id || rsp_y !== (exp_id ? 16'hFFB0 : 16'h8000) || rsp_flags !== (exp_id ? 4'b0100 : 4'b0101)) begin
          errors++;
          $display("FAIL rr_rsp: got id=%b y=%h fl=%b, expected id=%b y=%h fl=%b", rsp_id, rsp_y, rsp_flags,
                   exp_id, exp_id ? 16'hFFB0 : 16'h8000, exp_id ? 4'b0100 : 4'b0101);
        end
        rsps++;
      end
      if (fp_r1_ready) begin
        checks++; errors++;
        $display("FAIL fp_grant: got fp_r1_ready=1 while r0 valid, expected 0");
      end
      if (fp_rsp_valid) begin
        checks++;
        if (fp_rsp_id !== 1'b0 || fp_rsp_y !== 16'h8000 || fp_rsp_flags !== 4'b0101) begin
          errors++;
          $display("FAIL fp_rsp: got id=%b y=%h fl=%b, expected id=0 y=8000 fl=0101", fp_rsp_id, fp_rsp_y, fp_rsp_flags);
        end
        fp_rsps++;
      end
    end
    @(posedge clk); #1;
    release_req(1'b0);
    release_req(1'b1);
    checks++;
    if (rsps != 4 || fp_rsps < 3) begin
      errors++;
      $display("FAIL rr_count: got %0d responses (fixed prio %0d), expected 4 (at least 3)", rsps, fp_rsps);
    end
  endtask

  task automatic test_backpressure();
    int wc, lat; bit ok, ok2, bad; logic id; logic [15:0] y, hi; logic [3:0] fl, fg;
    logic [15:0] sy, shi; logic [3:0] sfl; logic sid;
    rsp_ready = 1'b0;
    send(1'b0, 16'h1234, 16'h0101, 4'b0010, 1'b0, wc, ok);
    model_favour = 1'b1;
    drive(1'b1, 16'h00F0, 16'h0F0F, 4'b1101, 1'b0);
    bad = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin
      if (r0_ready || r1_ready) bad = 1'b1;
      lat++;
      @(negedge clk);
    end
    sy = rsp_y; shi = rsp_hi; sfl = rsp_flags; sid = rsp_id;
    checks++;
    if (!ok || !rsp_valid || lat != 2 || sy !== 16'h1133 || sfl !== 4'b0000 || sid !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: got valid=%b lat=%0d y=%h fl=%b id=%b, expected lat 2 y=1133 fl=0000 id=0",
               rsp_valid, lat, sy, sfl, sid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_y !== sy || rsp_hi !== shi || rsp_flags !== sfl || rsp_id !== sid ||
          r0_ready !== 1'b0 || r1_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL bp_hold: got unstable response or ready during stall, expected held and no ready"); end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || r1_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_grant: got rsp_valid=%b r1_ready=%b, expected 0 and 1", rsp_valid, r1_ready);
    end
    model_favour = 1'b0;
    @(posedge clk); #1;
    release_req(1'b1);
    recv(ok2, lat, id, y, hi, fl, fg);
    checks++;
    if (!ok2 || lat != 2 || y !== 16'h0FFF || fl !== 4'b0000 || id !== 1'b1) begin
      errors++;
      $display("FAIL bp_r1: got lat=%0d y=%h fl=%b id=%b, expected lat 2 y=0fff fl=0000 id=1", lat, y, fl, id);
    end
  endtask

  task automatic test_random();
    logic [15:0] a [2];
    logic [15:0] b [2];
    logic [3:0]  f [2];
    logic        c [2];
    bit          pend [2];
    int mask, wc, lat;
    bit ok, exp_id, got_id;
    logic id; logic [15:0] y, hi; logic [3:0] fl, fg;
    alu_out_t e;
    for (int k = 0; k < 40; k++) begin
      mask = int'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) begin
        a[i] = 16'($urandom); b[i] = 16'($urandom); f[i] = 4'($urandom); c[i] = 1'($urandom);
        pend[i] = mask[i];
      end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) if (pend[i]) drive(1'(i), a[i], b[i], f[i], c[i]);
      while (pend[0] || pend[1]) begin
        exp_id = (pend[0] && pend[1]) ? model_favour : pend[1];
        wc = 0;
        @(negedge clk);
        while (!(r0_ready || r1_ready) && wc < 20) begin wc++; @(negedge clk); end
        checks++;
        if (!(r0_ready ^ r1_ready) || r1_ready !== exp_id || wc != 0) begin
          errors++;
          $display("FAIL rand_grant[%0d]: got r0_ready=%b r1_ready=%b wait=%0d, expected requester %0d now",
                   k, r0_ready, r1_ready, wc, exp_id);
          @(posedge clk); #1;
          release_req(1'b0); release_req(1'b1);
          pend[0] = 1'b0; pend[1] = 1'b0;
          do_reset();
        end else begin
          got_id = r1_ready;
          model_favour = !got_id;
          @(posedge clk); #1;
          release_req(got_id);
          pend[got_id] = 1'b0;
          recv(ok, lat, id, y, hi, fl, fg);
          e = alu_model(a[got_id], b[got_id], f[got_id], c[got_id]);
          checks++;
          if (!ok || lat != 2 || id !== got_id || y !== e.y || hi !== e.hi || fl !== e.fl || fg !== e.fl) begin
            errors++;
            $display("FAIL rand_rsp[%0d]: got lat=%0d id=%b y=%h hi=%h fl=%b flags=%b, expected lat 2 id=%b y=%h hi=%h fl=%b",
                     k, lat, id, y, hi, fl, fg, got_id, e.y, e.hi, e.fl);
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish within time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_a = '0; r0_b = '0; r0_func = '0; r0_ci = 1'b0;
    r1_a = '0; r1_b = '0; r1_func = '0; r1_ci = 1'b0;
    test_reset();
    test_basic_add();
    test_mul();
    test_flags_chain();
    test_reset_abort();
    test_round_robin();
    test_backpressure();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
